// File: rtl/sr_bank_ctrl.sv
// Round-robin controller sharing one bank of W SR flops among NREQ requesters.
// Each grant drives a one-cycle conflict-free s/r pulse, then checks the bank's readback.
module sr_bank_ctrl #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              c,
  input  logic              rs,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] smask,
  input  logic [NREQ*W-1:0] rmask,
  input  logic [W-1:0]      q_in,
  output logic [W-1:0]      s_out,
  output logic [W-1:0]      r_out,
  output logic              bank_rst,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [W-1:0]    sm_q;
  logic [W-1:0]    rm_q;
  logic [W-1:0]    cf_q;
  logic [W-1:0]    s_q;
  logic [W-1:0]    r_q;
  logic [NREQ-1:0] gnt_q;
  logic            done_q;
  logic            busy_q;
  logic            bank_rst_q;

  logic            found_d;
  logic            hit_d;
  logic [IW-1:0]   win_d;
  logic [IW:0]     cand_d;
  logic [W-1:0]    sm_d;
  logic [W-1:0]    rm_d;
  logic [IW-1:0]   ptr_inc_d;
  logic            mismatch_d;

  // Round-robin winner search, starting at ptr_q and wrapping modulo NREQ
  always_comb begin
    found_d = 1'b0;
    hit_d   = 1'b0;
    win_d   = ptr_q;
    cand_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_d  = {1'b0, ptr_q} + (IW+1)'(i);
      cand_d  = (cand_d >= (IW+1)'(NREQ)) ? (cand_d - (IW+1)'(NREQ)) : cand_d;
      hit_d   = !found_d && req[cand_d[IW-1:0]];
      win_d   = hit_d ? cand_d[IW-1:0] : win_d;
      found_d = found_d | hit_d;
    end
    sm_d = smask[int'(win_d)*W +: W];
    rm_d = rmask[int'(win_d)*W +: W];
  end

  // Pointer advance and readback comparison over non-conflict mask bits only
  always_comb begin
    ptr_inc_d  = (win_q == IW'(NREQ-1)) ? '0 : (win_q + IW'(1));
    mismatch_d = |(((sm_q & ~cf_q) & ~q_in) | ((rm_q & ~cf_q) & q_in));
  end

  // Controller FSM; the first edge after reset release only clears the bank
  always_ff @(posedge c or negedge rs) begin
    if (!rs) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      sm_q       <= '0;
      rm_q       <= '0;
      cf_q       <= '0;
      s_q        <= '0;
      r_q        <= '0;
      gnt_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      bank_rst_q <= 1'b1;
    end else if (bank_rst_q) begin
      bank_rst_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q  <= '0;
          done_q <= 1'b0;
          if (found_d) begin
            win_q   <= win_d;
            sm_q    <= sm_d;
            rm_q    <= rm_d;
            cf_q    <= sm_d & rm_d;
            busy_q  <= 1'b1;
            state_q <= DRIVE;
          end else begin
            state_q <= IDLE;
          end
        end
        DRIVE: begin
          // Conflict bits are masked out of both pulses, so s & r is never set
          s_q     <= sm_q & ~cf_q;
          r_q     <= rm_q & ~cf_q;
          gnt_q   <= NREQ'(1'b1) << win_q;
          state_q <= CHECK;
        end
        CHECK: begin
          s_q     <= '0;
          r_q     <= '0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_inc_d;
          state_q <= IDLE;
        end
        default: begin
          s_q     <= '0;
          r_q     <= '0;
          gnt_q   <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_out    = s_q;
  assign r_out    = r_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign bank_rst = bank_rst_q;
  // The bank captures on the same edge that raises done, so the readback part
  // of err is judged on the live q_in while the registered done is high.
  assign err      = done_q & ((|cf_q) | mismatch_d);

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Directed bench for sr_bank_ctrl with a behavioural SR flop bank (stuck-at-0 injectable).
module tb_sr_bank_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic        clk;
  logic        rs;
  logic [3:0]  req;
  logic [31:0] smask;
  logic [31:0] rmask;
  logic [7:0]  q_in;
  logic [7:0]  s_out;
  logic [7:0]  r_out;
  logic        bank_rst;
  logic [3:0]  gnt;
  logic        done;
  logic        err;
  logic        busy;
  logic [7:0]  bank_q;
  logic [7:0]  stuck;

  int tests = 0;
  int fails = 0;

  sr_bank_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .c        (clk),
    .rs       (rs),
    .req      (req),
    .smask    (smask),
    .rmask    (rmask),
    .q_in     (q_in),
    .s_out    (s_out),
    .r_out    (r_out),
    .bank_rst (bank_rst),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SR flop bank: sync active-high reset, set/clear per bit
  always @(posedge clk) begin
    if (bank_rst) bank_q <= 8'h00;
    else          bank_q <= (bank_q | s_out) & ~r_out;
  end

  assign q_in = bank_q & ~stuck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("s_and_r", {24'h0, s_out & r_out}, 32'h0);
  endtask

  // One transaction: sample edge, drive edge, check edge. Masks are scrambled
  // after sampling to show they were latched.
  task automatic txn(input logic [3:0] rq, input logic [31:0] sm, input logic [31:0] rm,
                     input logic [3:0] eg, input logic [7:0] es, input logic [7:0] er,
                     input logic ee, input logic [7:0] eq);
    req   = rq;
    smask = sm;
    rmask = rm;
    tick();
    chk("latch_busy", {31'h0, busy}, 32'h1);
    chk("latch_gnt",  {28'h0, gnt},  32'h0);
    chk("latch_done", {31'h0, done}, 32'h0);
    smask = ~sm;
    rmask = ~rm;
    tick();
    chk("drive_gnt",  {28'h0, gnt},   {28'h0, eg});
    chk("drive_s",    {24'h0, s_out}, {24'h0, es});
    chk("drive_r",    {24'h0, r_out}, {24'h0, er});
    chk("drive_done", {31'h0, done},  32'h0);
    tick();
    chk("check_done", {31'h0, done},  32'h1);
    chk("check_err",  {31'h0, err},   {31'h0, ee});
    chk("check_gnt",  {28'h0, gnt},   {28'h0, eg});
    chk("check_sr",   {24'h0, s_out | r_out}, 32'h0);
    chk("check_busy", {31'h0, busy},  32'h0);
    chk("readback_q", {24'h0, q_in},  {24'h0, eq});
  endtask

  task automatic idle_gap();
    req = 4'b0000;
    tick();
    chk("gap_done", {31'h0, done}, 32'h0);
    chk("gap_err",  {31'h0, err},  32'h0);
    chk("gap_gnt",  {28'h0, gnt},  32'h0);
    chk("gap_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    rs    = 1'b0;
    req   = 4'b0000;
    smask = 32'h0;
    rmask = 32'h0;
    stuck = 8'h00;
    tick();
    tick();
    chk("rst_gnt",      {28'h0, gnt},      32'h0);
    chk("rst_s",        {24'h0, s_out},    32'h0);
    chk("rst_r",        {24'h0, r_out},    32'h0);
    chk("rst_done",     {31'h0, done},     32'h0);
    chk("rst_err",      {31'h0, err},      32'h0);
    chk("rst_busy",     {31'h0, busy},     32'h0);
    chk("rst_bank_rst", {31'h0, bank_rst}, 32'h1);

    rs = 1'b1;
    tick();
    chk("rel_bank_rst", {31'h0, bank_rst}, 32'h0);
    chk("rel_q",        {24'h0, q_in},     32'h0);

    // Single set then clear by requester 1 (ptr 0 -> 2)
    txn(4'b0010, 32'h0000A500, 32'h00000000, 4'b0010, 8'hA5, 8'h00, 1'b0, 8'hA5);
    idle_gap();
    txn(4'b0010, 32'h00000000, 32'h00000500, 4'b0010, 8'h00, 8'h05, 1'b0, 8'hA0);
    idle_gap();

    // Abort: requester 2 wins from ptr 2, reset pulled mid-cycle while driving
    req   = 4'b0100;
    smask = 32'h00FF0000;
    rmask = 32'h0;
    tick();
    chk("abort_busy", {31'h0, busy}, 32'h1);
    tick();
    chk("abort_gnt", {28'h0, gnt},   32'h4);
    chk("abort_s",   {24'h0, s_out}, 32'hFF);
    #2;
    rs = 1'b0;
    #1;
    chk("abort_gnt0",     {28'h0, gnt},      32'h0);
    chk("abort_s0",       {24'h0, s_out},    32'h0);
    chk("abort_done0",    {31'h0, done},     32'h0);
    chk("abort_busy0",    {31'h0, busy},     32'h0);
    chk("abort_bank_rst", {31'h0, bank_rst}, 32'h1);
    req   = 4'b1111;
    smask = 32'h08040201;
    rmask = 32'h0;
    tick();
    chk("abort_nodone", {31'h0, done}, 32'h0);
    rs = 1'b1;
    tick();
    chk("abort_rel_bank_rst", {31'h0, bank_rst}, 32'h0);
    chk("abort_rel_nogrant",  {31'h0, busy},     32'h0);
    chk("abort_rel_q",        {24'h0, q_in},     32'h0);

    // Round robin with all requests held: 0,1,2,3,0 back-to-back
    txn(4'b1111, 32'h08040201, 32'h0, 4'b0001, 8'h01, 8'h00, 1'b0, 8'h01);
    txn(4'b1111, 32'h08040201, 32'h0, 4'b0010, 8'h02, 8'h00, 1'b0, 8'h03);
    txn(4'b1111, 32'h08040201, 32'h0, 4'b0100, 8'h04, 8'h00, 1'b0, 8'h07);
    txn(4'b1111, 32'h08040201, 32'h0, 4'b1000, 8'h08, 8'h00, 1'b0, 8'h0F);
    txn(4'b1111, 32'h08040201, 32'h0, 4'b0001, 8'h01, 8'h00, 1'b0, 8'h0F);
    idle_gap();

    // Fill to 0xFF, then conflict: set 0x0F, clear 0x3C
    txn(4'b0001, 32'h000000FF, 32'h0,        4'b0001, 8'hFF, 8'h00, 1'b0, 8'hFF);
    idle_gap();
    txn(4'b0001, 32'h0000000F, 32'h0000003C, 4'b0001, 8'h03, 8'h30, 1'b1, 8'hCF);
    idle_gap();

    // Bit 7 stuck at 0 on readback, set 0x80
    stuck = 8'h80;
    txn(4'b0001, 32'h00000080, 32'h0, 4'b0001, 8'h80, 8'h00, 1'b1, 8'h4F);
    idle_gap();
    stuck = 8'h00;

    // Wrap: ptr 1 with req 1001 picks 3, then 0 with empty masks
    txn(4'b1001, 32'h0, 32'h0F000000, 4'b1000, 8'h00, 8'h0F, 1'b0, 8'hC0);
    txn(4'b1001, 32'h0, 32'h0F000000, 4'b0001, 8'h00, 8'h00, 1'b0, 8'hC0);
    idle_gap();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_bank_ctrl.md
# sr_bank_ctrl

Round-robin controller that shares one bank of W SR flip-flops (each bit an `SRff`-style cell: `s`, `r`, sync active-high reset, posedge clock) among NREQ requesters. A granted requester's set/clear masks are applied to the bank as a one-cycle `s`/`r` pulse, then the bank's `q` outputs are read back and checked. The block sits between the requesting logic and the flop bank. It is the only driver of the bank's `s`, `r` and reset inputs, and it guarantees the illegal `s=r=1` code is never driven.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, bank width in bits
- c  in  1  clock, rising edge
- rs  in  1  reset, asynchronous, active-low
- req  in  NREQ  request per requester; held high until its `done`
- smask  in  NREQ*W  set masks; requester k occupies bits [k*W +: W]
- rmask  in  NREQ*W  clear masks; requester k occupies bits [k*W +: W]
- q_in  in  W  bank `q` outputs (feedback)
- s_out  out  W  bank `s` inputs
- r_out  out  W  bank `r` inputs
- bank_rst  out  1  bank sync reset (active-high)
- gnt  out  NREQ  one-hot grant, held for the whole transaction
- done  out  1  one-cycle completion pulse
- err  out  1  valid with `done`: conflict or readback mismatch
- busy  out  1  high when the FSM is not in IDLE

## Operation
- FSM states: IDLE, DRIVE, CHECK. All outputs are registered.
- IDLE, when any `req` is high:
  - Pick the winner round-robin. Search from `ptr` upward and wrap modulo NREQ.
  - Latch the winner index, its smask and its rmask.
  - Compute the conflict mask `cf = smask & rmask`.
  - Go to DRIVE.
- DRIVE (1 cycle):
  - `s_out = smask & ~cf`, `r_out = rmask & ~cf`.
  - `gnt[winner] = 1`, `busy = 1`.
  - Go to CHECK.
- CHECK (1 cycle):
  - `s_out = r_out = 0`. `gnt` is held.
  - `done = 1`.
  - `err = (cf != 0) | mismatch`. `mismatch` is any set bit (non-conflict) with `q_in = 0`, or any clear bit (non-conflict) with `q_in = 1`.
  - `ptr = (winner + 1) mod NREQ`.
  - Go to IDLE.
- Conflict bits are neither set nor cleared, so the bank holds them. Conflict alone still raises `err`.
- Bits in neither mask are left untouched and are not checked.
- Masks are latched in IDLE. Changes to `req` or the masks after that are ignored until `done`.
- Dropping `req` mid-transaction has no effect; the transaction completes.
- Empty masks (both 0) run the full sequence and give `done = 1`, `err = 0`.
- The invariant `s_out & r_out == 0` holds in every cycle.

## Timing
- Reset values (`rs` low, asynchronous):
  - state = IDLE, `ptr = 0`.
  - `gnt`, `s_out`, `r_out`, `done`, `err`, `busy` = 0.
  - `bank_rst = 1`.
- `bank_rst` drops to 0 on the first rising edge after `rs` releases. The bank therefore clears on that edge, and the controller performs no grant in that cycle.
- Reset mid-transaction aborts it immediately: no `done`, and all outputs return to their reset values.
- Latency is 3 cycles from `req` sampled in IDLE at edge 0:
  - `gnt`, `s_out`, `r_out` valid after edge 1.
  - The bank captures at edge 2.
  - `done`/`err` are valid after edge 2 and deassert after edge 3.
- Throughput: one transaction per 3 cycles. With back-to-back requests, IDLE lasts exactly one cycle between transactions.
- Requests arriving while `busy` wait; arbitration uses `ptr` at the time IDLE samples them.

## Test plan
- Reset/bank clear:
  - Pull `rs` low mid-cycle; all outputs go to reset values asynchronously and `bank_rst = 1`.
  - Release `rs`; after one edge `bank_rst = 0` and `q_in = 0x00`.
- Single set/clear, NREQ=4, W=8:
  - `req = 4'b0010`, `smask[1] = 0xA5`, `rmask[1] = 0x00` → `gnt = 0010`, `s_out = 0xA5` for one cycle, then `done = 1`, `err = 0`, `q_in = 0xA5`.
  - Then `rmask[1] = 0x05` → `q_in = 0xA0`, `err = 0`.
- Round-robin fairness:
  - Hold `req = 4'b1111` continuously → grant order 0, 1, 2, 3, 0.
  - Each `gnt` lasts 2 cycles, with `done` every 3 cycles.
- Conflict:
  - `smask = 0x0F`, `rmask = 0x3C` from `q_in = 0xFF` → `s_out = 0x03`, `r_out = 0x30`.
  - Result `q_in = 0xCF`; `done = 1` with `err = 1`.
  - `s_out & r_out` is never nonzero.
- Readback mismatch: force bank bit 7 stuck at 0, then set `smask = 0x80` → `done = 1`, `err = 1`.
- Abort and wrap:
  - Assert `rs` low during DRIVE → no `done`, and `ptr` returns to 0.
  - With `req = 4'b1001`, grant requester 3, then wrap to requester 0.
